divmul_sequencer: RTL and testbench

//  Multi-cycle controller for the shared iterative multiply/divide unit of the ARM core.
//  - Accepts MUL, MLA, UDIV and SDIV requests from the decode stage.
//  - Holds the core with a stall while it runs a radix-2 shift/add or restoring-divide loop.
//  - Presents the result for a single writeback cycle.
//  - Sits between the controller (start/op) and the datapath (operands, result mux, PC enable).

---
 rtl/divmul_pkg.sv | 24 ++
 rtl/divmul_if.sv | 39 +++
 rtl/divmul_iter_core.sv | 74 +++++++
 rtl/divmul_sequencer.sv | 149 ++++++++++++++
 tb/tb_divmul_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/divmul_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: opcodes,
// FSM state encoding and default sizing.
package divmul_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_MLA  = 2'd1;
   localparam logic [1:0] OP_UDIV = 2'd2;
   localparam logic [1:0] OP_SDIV = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Both divide opcodes share the upper opcode bit.
   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/divmul_if.sv
// Decode-side request/response bundle for the multiply/divide sequencer.
// The div0 member only exists when DIVMUL_DIV0_TRAP_EN is defined.
interface divmul_if
   import divmul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic             flush;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef DIVMUL_DIV0_TRAP_EN
   logic             div0;

   modport master (
      output start, op, a, b, acc, flush,
      input  stall, busy, done, result, div0
   );
   modport slave (
      input  start, op, a, b, acc, flush,
      output stall, busy, done, result, div0
   );
`else
   modport master (
      output start, op, a, b, acc, flush,
      input  stall, busy, done, result
   );
   modport slave (
      input  start, op, a, b, acc, flush,
      output stall, busy, done, result
   );
`endif
endinterface

// File: rtl/divmul_iter_core.sv
// One radix-2 iteration per step: LSB-first shift/add multiply or restoring
// divide on unsigned operands. Sign handling lives in the sequencer.
module divmul_iter_core
   import divmul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] opnd_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] acc_in,
   output logic [WIDTH-1:0] res_next
);

   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   diff_s;

   // Next-state of the datapath; the diff sign bit selects restore vs. keep.
   always_comb begin
      opnd_d  = opnd_q;
      q_d     = q_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      shift_s = {rem_q, q_q[WIDTH-1]};
      diff_s  = shift_s - {1'b0, opnd_q};
      if (load) begin
         opnd_d = opnd_in;
         q_d    = q_in;
         acc_d  = acc_in;
         rem_d  = {WIDTH{1'b0}};
      end else if (step) begin
         if (div_mode) begin
            if (!diff_s[WIDTH]) begin
               rem_d = diff_s[WIDTH-1:0];
               q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shift_s[WIDTH-1:0];
               q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d  = acc_q + (q_q[0] ? opnd_q : {WIDTH{1'b0}});
            opnd_d = opnd_q << 1;
            q_d    = q_q >> 1;
         end
      end else begin
         rem_d = rem_q;
      end
      res_next = div_mode ? q_d : acc_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opnd_q <= {WIDTH{1'b0}};
         q_q    <= {WIDTH{1'b0}};
         acc_q  <= {WIDTH{1'b0}};
         rem_q  <= {WIDTH{1'b0}};
      end else begin
         opnd_q <= opnd_d;
         q_q    <= q_d;
         acc_q  <= acc_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/divmul_sequencer.sv
// Multi-cycle controller for the shared multiply/divide unit: FSM, iteration
// counter, sign fix-up, stall/done. Optional div0 strobe via DIVMUL_DIV0_TRAP_EN.
module divmul_sequencer
   import divmul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic     clk,
   input logic     reset,
   divmul_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic             load_s;
   logic             step_s;
   logic             div_mode_s;
   logic             sdiv_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic [WIDTH-1:0] opnd_in_s;
   logic [WIDTH-1:0] q_in_s;
   logic [WIDTH-1:0] acc_in_s;
   logic [WIDTH-1:0] res_next_s;

   // Operand conditioning: divides run on magnitudes, MUL starts from zero.
   always_comb begin
      sdiv_s     = (bus.op == OP_SDIV);
      a_mag_s    = (sdiv_s && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
      b_mag_s    = (sdiv_s && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
      opnd_in_s  = is_div(bus.op) ? b_mag_s : bus.a;
      q_in_s     = is_div(bus.op) ? a_mag_s : bus.b;
      acc_in_s   = (bus.op == OP_MLA) ? bus.acc : {WIDTH{1'b0}};
      div_mode_s = (state_q == S_IDLE) ? is_div(bus.op) : is_div(op_q);
   end

   // FSM next-state, counter and result capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      div0_d   = 1'b0;
      load_s   = 1'b0;
      step_s   = 1'b0;
      if (bus.flush) begin
         state_d = S_IDLE;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  op_d   = bus.op;
                  neg_d  = sdiv_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  load_s = 1'b1;
                  if (is_div(bus.op) && (bus.b == {WIDTH{1'b0}})) begin
                     state_d  = S_DONE;
                     result_d = {WIDTH{1'b0}};
                     div0_d   = 1'b1;
                  end else begin
                     state_d = S_RUN;
                     cnt_d   = CNT_LAST;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               step_s = 1'b1;
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_d  = S_DONE;
                  result_d = neg_q ? ({WIDTH{1'b0}} - res_next_s) : res_next_s;
               end else begin
                  cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         result_q <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         div0_q   <= div0_d;
      end
   end

   divmul_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .step     (step_s),
      .div_mode (div_mode_s),
      .opnd_in  (opnd_in_s),
      .q_in     (q_in_s),
      .acc_in   (acc_in_s),
      .res_next (res_next_s)
   );

   // Stall must cover the request cycle itself, so it cannot wait for a flop.
   assign bus.stall  = ((state_q == S_IDLE) && bus.start) || (state_q == S_RUN);
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
`ifdef DIVMUL_DIV0_TRAP_EN
   assign bus.div0   = div0_q;
`else
   logic unused_div0_s;
   assign unused_div0_s = div0_q;
`endif

endmodule

// File: tb/tb_divmul_sequencer.sv
// Randomized self-checking bench for divmul_sequencer against an arithmetic
// reference model (64-bit integer math on the architectural rules).
module tb_divmul_sequencer;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [W-1:0] last_res;

   divmul_if #(.WIDTH(W)) bus ();

   divmul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] acc);
      longint unsigned p;
      longint          sa, sb, sq;
      logic [63:0]     r;
      p  = longint'(a) * longint'(b);
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         2'd0: r = p;
         2'd1: r = p + longint'(acc);
         2'd2: r = (b == 0) ? 64'd0 : longint'(a) / longint'(b);
         default: begin
            sq = (b == 0) ? 64'sd0 : sa / sb;
            r  = sq;
         end
      endcase
      return r[W-1:0];
   endfunction

   // Issue one request at a negedge and follow it to its done strobe.
   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] acc, input bit hold);
      logic [W-1:0] exp;
      int exp_lat, cyc, stalls;
      bit dz;
      dz      = op[1] && (b == 0);
      exp     = model(op, a, b, acc);
      exp_lat = dz ? 2 : W + 2;
      bus.op = op; bus.a = a; bus.b = b; bus.acc = acc; bus.start = 1'b1;
      cyc = 1; stalls = 0;
      while (cyc < 60) begin
         #1;
         if (bus.done) break;
         if (bus.stall) stalls++;
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         cyc++;
      end
      check_eq($sformatf("latency op%0d", op), cyc, exp_lat);
      check_eq($sformatf("stall_cycles op%0d", op), stalls, exp_lat - 1);
      check_eq($sformatf("result op%0d a=%0h b=%0h", op, a, b), bus.result, exp);
      check_eq("stall_in_done", bus.stall, 1'b0);
`ifdef DIVMUL_DIV0_TRAP_EN
      check_eq("div0", bus.div0, dz);
`endif
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check_eq("done_one_cycle", bus.done, 1'b0);
      check_eq("idle_after_done", bus.busy, 1'b0);
      check_eq("result_hold", bus.result, exp);
      last_res = exp;
      @(negedge clk);
   endtask

   // Start a multiply, then abort it at RUN cycle 10 by flush or by reset.
   task automatic abort_op(input bit use_reset);
      int dones;
      bus.op = 2'd0; bus.a = $urandom; bus.b = $urandom; bus.acc = 0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      if (use_reset) rst_n = 1'b0;
      else bus.flush = 1'b1;
      if (use_reset) begin
         #1;
         last_res = '0;
      end else begin
         @(negedge clk);
         bus.flush = 1'b0;
         #1;
      end
      check_eq(use_reset ? "rst_busy" : "flush_busy", bus.busy, 1'b0);
      check_eq(use_reset ? "rst_stall" : "flush_stall", bus.stall, 1'b0);
      check_eq(use_reset ? "rst_done" : "flush_done", bus.done, 1'b0);
      check_eq(use_reset ? "rst_result" : "flush_result", bus.result, last_res);
      if (use_reset) begin
         @(negedge clk);
         rst_n = 1'b1;
      end
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (bus.done) dones++;
      end
      check_eq(use_reset ? "rst_no_done" : "flush_no_done", dones, 0);
      @(negedge clk);
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b, acc;
      checks = 0; errors = 0; last_res = '0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0; bus.acc = '0; bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_stall", bus.stall, 1'b0);
      check_eq("reset_busy", bus.busy, 1'b0);
      check_eq("reset_done", bus.done, 1'b0);
      check_eq("reset_result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(2'd0, 32'd7, 32'd6, 32'd0, 1'b0);
      do_op(2'd1, 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b0);
      do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
      do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
      do_op(2'd2, 32'd100, 32'd0, 32'd0, 1'b0);
      do_op(2'd3, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1);
      do_op(2'd0, 32'd12345, 32'd678, 32'd0, 1'b1);
      do_op(2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

      abort_op(1'b0);
      abort_op(1'b1);

      // Flush together with start in IDLE drops the request.
      bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      #1;
      check_eq("flush_start_dropped", bus.busy, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
               ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
         if ($urandom_range(0, 1) == 1) b = -b;
         acc = $urandom;
         do_op(op, a, b, acc, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
